// File: rtl/debug_uart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | debug_uart_tx_if : core-side byte stream and status of the debug UART TX    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface debug_uart_tx_if #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
    logic [7:0]       tx_Data;
    logic             tx_DataValid;
    logic             ovf_clr;
    logic             uart_txd;
    logic             busy;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    modport master (
        output tx_Data, tx_DataValid, ovf_clr,
        input  uart_txd, busy, fifo_full, fifo_count, overflow
    );

    modport slave (
        input  tx_Data, tx_DataValid, ovf_clr,
        output uart_txd, busy, fifo_full, fifo_count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/debug_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | debug_uart_tx : FIFO-buffered 8N1 debug UART transmitter, LSB first.        |
// | Define DEBUG_UART_PARITY_EN to add an even-parity bit (8E1).                |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module debug_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic           clk,
    input  logic           resetn,
    debug_uart_tx_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] c_LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  c_DEPTH     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef DEBUG_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        mem [FIFO_DEPTH];

    logic       w_pop, w_push, w_bit_end, w_has_data;
    logic [7:0] w_head;

    assign w_head     = mem[rd_ptr_q];
    assign w_has_data = (count_q != '0);
    assign w_bit_end  = (baud_q == c_LAST_BAUD);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push     = bus.tx_DataValid && ((count_q < c_DEPTH) || w_pop);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        w_pop   = 1'b0;
        if (state_q != S_IDLE) begin
            baud_d = w_bit_end ? '0 : baud_q + BAUD_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (w_has_data) begin
                    w_pop   = 1'b1;
                    shift_d = w_head;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef DEBUG_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef DEBUG_UART_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (w_has_data) begin
                        w_pop   = 1'b1;
                        shift_d = w_head;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef DEBUG_UART_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    par_q <= 1'b0;
        else if (w_pop) par_q <= ^w_head;
    end
`endif

    // Line level is derived from the next state so the pin is a clean flop output.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef DEBUG_UART_PARITY_EN
            S_PARITY: txd_d = par_q;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (w_push && !w_pop)      count_d = count_q + CNT_W'(1);
        else if (!w_push && w_pop) count_d = count_q - CNT_W'(1);
        if (bus.tx_DataValid && !w_push) ovf_d = 1'b1;
        else if (bus.ovf_clr)            ovf_d = 1'b0;
    end

    assign full_d = (count_d == c_DEPTH);

    always_ff @(posedge clk) begin
        if (w_push) mem[wr_ptr_q] <= bus.tx_Data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.uart_txd   = txd_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.fifo_full  = full_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_debug_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_debug_uart_tx : scoreboard bench with serial-line decoder for the TX.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_debug_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef DEBUG_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    debug_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    debug_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int         tests       = 0;
    int         fails       = 0;
    int         frames_seen = 0;
    int         exp_frames  = 0;
    logic [7:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level of bit slot i of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef DEBUG_UART_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic drive(input logic [7:0] b, input logic expect_tx);
        bus.tx_Data      = b;
        bus.tx_DataValid = 1'b1;
        if (expect_tx) begin
            sb_q.push_back(b);
            exp_frames++;
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((bus.busy !== 1'b0 || bus.fifo_count !== '0) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) begin
            tests++;
            fails++;
            $display("FAIL wait_idle_timeout: busy=%b count=%0d", bus.busy, bus.fifo_count);
        end
        repeat (2) @(negedge clk);
    endtask

    // Serial decoder: samples each bit slot mid-way and scores the whole frame.
    initial begin : monitor
        logic [NBITS-1:0] got, want;
        logic [7:0]       e;
        int               cur;
        logic             abort;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && bus.uart_txd === 1'b0) begin
                cur   = 0;
                abort = 1'b0;
                got   = '0;
                for (int i = 0; i < NBITS; i++) begin
                    repeat (i * CPB + CPB / 2 - cur) @(negedge clk);
                    cur = i * CPB + CPB / 2;
                    if (resetn !== 1'b1) abort = 1'b1;
                    got[i] = bus.uart_txd;
                end
                repeat (FRAME - 1 - cur) @(negedge clk);
                if (!abort) begin
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame: bits %0h with no byte pending", got);
                    end else begin
                        e = sb_q.pop_front();
                        for (int i = 0; i < NBITS; i++) want[i] = frame_bit(e, i);
                        chk("rx_frame", 32'(got), 32'(want));
                        frames_seen++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int         bad, maxc, g;
        logic [7:0] b;
        logic [7:0] ov [6];

        bus.tx_Data      = '0;
        bus.tx_DataValid = 1'b0;
        bus.ovf_clr      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(bus.uart_txd), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_count", 32'(bus.fifo_count), 0);
        chk("rst_full", 32'(bus.fifo_full), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        resetn = 1'b1;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.uart_txd !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_count !== '0) bad++;
        end
        chk("reset_idle_bad_cycles", 32'(bad), 0);

        // Single byte: exact waveform, one bit slot per CPB cycles.
        drive(8'hA5, 1'b1);
        @(negedge clk);
        bus.tx_DataValid = 1'b0;
        chk("single_txd_before_pop", 32'(bus.uart_txd), 1);
        chk("single_count_after_push", 32'(bus.fifo_count), 1);
        bad = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (bus.uart_txd !== frame_bit(8'hA5, (k - 1) / CPB)) bad++;
            if (bus.busy !== 1'b1) bad++;
        end
        chk("single_wave_bad", 32'(bad), 0);
        @(negedge clk);
        chk("single_busy_end", 32'(bus.busy), 0);
        wait_idle();

        // Back-to-back: second frame's start bit follows the first stop bit directly.
        drive(8'h00, 1'b1);
        @(negedge clk);
        drive(8'hFF, 1'b1);
        @(negedge clk);
        bus.tx_DataValid = 1'b0;
        bad  = 0;
        maxc = 1;
        chk("b2b_count_after_pushes", 32'(bus.fifo_count), 1);
        for (int k = 1; k <= 2 * FRAME; k++) begin
            if (k > 1) @(negedge clk);
            b = (k <= FRAME) ? 8'h00 : 8'hFF;
            if (bus.uart_txd !== frame_bit(b, ((k - 1) % FRAME) / CPB)) bad++;
            if (bus.busy !== 1'b1) bad++;
            if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
        end
        chk("b2b_wave_bad", 32'(bad), 0);
        chk("b2b_count_peak", 32'(maxc), 1);
        @(negedge clk);
        chk("b2b_busy_end", 32'(bus.busy), 0);
        wait_idle();

        // Overflow: six bytes into an empty depth-4 FIFO; the sixth is lost.
        // A clear coinciding with the drop must lose to the set.
        for (int i = 0; i < 6; i++) ov[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            drive(ov[i], i < 5);
            bus.ovf_clr = (i == 5);
            @(negedge clk);
        end
        bus.tx_DataValid = 1'b0;
        bus.ovf_clr      = 1'b0;
        chk("ovf_full", 32'(bus.fifo_full), 1);
        chk("ovf_count", 32'(bus.fifo_count), 4);
        chk("ovf_set_wins", 32'(bus.overflow), 1);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(bus.overflow), 0);
        wait_idle();

        // Full FIFO accepts a byte on the exact cycle the stop bit ends and pops.
        for (int i = 0; i < 5; i++) begin
            drive(8'($urandom), 1'b1);
            @(negedge clk);
        end
        bus.tx_DataValid = 1'b0;
        repeat (FRAME - 4) @(negedge clk);
        chk("fpp_full_before", 32'(bus.fifo_full), 1);
        drive(8'h3C, 1'b1);
        @(negedge clk);
        bus.tx_DataValid = 1'b0;
        chk("fpp_count", 32'(bus.fifo_count), 4);
        chk("fpp_full_after", 32'(bus.fifo_full), 1);
        chk("fpp_ovf", 32'(bus.overflow), 0);
        wait_idle();

        // Mid-frame reset during data bit 3 of a zero byte.
        drive(8'h00, 1'b1);
        @(negedge clk);
        drive(8'h81, 1'b1);
        @(negedge clk);
        bus.tx_DataValid = 1'b0;
        repeat (1 + 3 * CPB + CPB / 2) @(negedge clk);
        chk("mrst_pre_txd", 32'(bus.uart_txd), 0);
        #1 resetn = 1'b0;
        #1;
        chk("mrst_txd", 32'(bus.uart_txd), 1);
        chk("mrst_count", 32'(bus.fifo_count), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        sb_q.delete();
        exp_frames -= 2;
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.uart_txd !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        chk("mrst_silent_after", 32'(bad), 0);

        // Random bytes with random gaps, never more outstanding than the FIFO holds.
        for (int n = 0; n < 30; n++) begin
            g = 0;
            while (sb_q.size() >= DEPTH && g < 2000) begin
                @(negedge clk);
                g++;
            end
            if (g >= 2000) begin
                tests++;
                fails++;
                $display("FAIL rand_wait_timeout: pending=%0d", sb_q.size());
            end
            drive(8'($urandom), 1'b1);
            @(negedge clk);
            bus.tx_DataValid = 1'b0;
            repeat ($urandom_range(0, 2 * FRAME)) @(negedge clk);
        end
        wait_idle();
        chk("rand_ovf", 32'(bus.overflow), 0);
        chk("sb_empty", 32'(sb_q.size()), 0);
        chk("frames_total", 32'(frames_seen), 32'(exp_frames));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
